// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and TX handshake state encodings
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        FS_IDLE      = 2'd0,
        FS_ISSUE     = 2'd1,
        FS_WAIT_BUSY = 2'd2,
        FS_WAIT_DONE = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - circular byte RAM with read/write pointers, count and flags
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [UART_DW-1:0] wr_data,
    output logic [UART_DW-1:0] rd_data,
    output logic [AW:0]        count,
    output logic               full,
    output logic               empty
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [UART_DW-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter via start/data/busy handshake
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [UART_DW-1:0] wr_data,
    input  logic               flush,
    input  logic               clr_ovf,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        level,
    output logic               overflow,
    output logic               tx_start,
    output logic [UART_DW-1:0] tx_data,
    input  logic               tx_busy
);

    fsm_state_t         state;
    fsm_state_t         state_nxt;
    logic               pop;
    logic               push_ok;
    logic [UART_DW-1:0] rd_data;

    // The pop is exactly the IDLE->ISSUE transition; flush suppresses it.
    assign pop     = (state == FS_IDLE) && !empty && !tx_busy && !flush;
    assign push_ok = wr_en && !flush && (!full || pop);

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_ok),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .count   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE:      if (pop) state_nxt = FS_ISSUE;
            FS_ISSUE:     state_nxt = FS_WAIT_BUSY;
            FS_WAIT_BUSY: if (tx_busy) state_nxt = FS_WAIT_DONE;
            FS_WAIT_DONE: if (!tx_busy) state_nxt = FS_IDLE;
            default:      state_nxt = FS_IDLE;
        endcase
    end

    // Registered start/data so the transmitter sees no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            tx_start <= pop;
            if (pop) tx_data <= rd_data;
            if (wr_en && full && !pop) overflow <= 1'b1;
            else if (clr_ovf)          overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with queue model and transmitter model
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    logic xm_busy = 1'b0;
    logic xm_pend = 1'b0;
    int   xm_cnt = 0;
    logic force_busy = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] st_data[$];
    int         st_cyc[$];
    int         fall_cyc[$];

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_last = 8'h00;
    logic       m_due = 1'b0;
    logic       m_elig = 1'b1;
    logic       m_seen = 1'b0;
    logic       prev_busy = 1'b0;
    logic       pop_now;
    logic       full_now;

    int base;
    int fb;
    int t0;

    always #5 clk = ~clk;

    assign tx_busy = xm_busy | force_busy;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: busy rises the cycle after start and stays high 10 cycles.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            xm_busy = 1'b0;
            xm_pend = 1'b0;
            xm_cnt  = 0;
        end else begin
            if (xm_busy) begin
                xm_cnt = xm_cnt - 1;
                if (xm_cnt == 0) xm_busy = 1'b0;
            end
            if (xm_pend) begin
                xm_busy = 1'b1;
                xm_cnt  = 10;
                xm_pend = 1'b0;
            end
            if (tx_start) xm_pend = 1'b1;
        end
    end

    // Reference model: FIFO as a queue, issue allowed again one cycle after busy is seen falling.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_last    = 8'h00;
            m_due     = 1'b0;
            m_elig    = 1'b1;
            m_seen    = 1'b0;
            prev_busy = 1'b0;
        end else begin
            check("mdl_level", 32'(level), 32'(mq.size()));
            check("mdl_empty", 32'(empty), 32'(mq.size() == 0));
            check("mdl_full", 32'(full), 32'(mq.size() == DEPTH));
            check("mdl_overflow", 32'(overflow), 32'(m_ovf));
            check("mdl_tx_start", 32'(tx_start), 32'(m_due));
            check("mdl_tx_data", 32'(tx_data), 32'(m_last));
            if (tx_start) begin
                check("start_while_busy", 32'(tx_busy), 32'd0);
                st_data.push_back(tx_data);
                st_cyc.push_back(cyc);
            end
            if (prev_busy && !tx_busy) fall_cyc.push_back(cyc);
            prev_busy = tx_busy;

            full_now = (mq.size() == DEPTH);
            pop_now  = m_elig && (mq.size() != 0) && !tx_busy && !flush;
            m_due    = pop_now;
            if (clr_ovf) m_ovf = 1'b0;
            if (wr_en && full_now && !pop_now) m_ovf = 1'b1;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop_now) begin
                    m_last = mq.pop_front();
                    m_elig = 1'b0;
                    m_seen = 1'b0;
                end
                if (wr_en && (!full_now || pop_now)) mq.push_back(wr_data);
            end
            if (!m_elig && !pop_now) begin
                if (tx_busy)     m_seen = 1'b1;
                else if (m_seen) m_elig = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic settle();
        repeat (20) step();
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (st_data.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(st_data.size() >= n), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        step();
        step();

        // Single byte: start one cycle after the push edge.
        base = st_data.size();
        push(8'hA5);
        t0 = cyc;
        step();
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_level", 32'(level), 32'd0);
        settle();
        check("single_count", 32'(st_data.size() - base), 32'd1);
        check("single_cycle", 32'(st_cyc[base] - t0), 32'd1);

        // Burst ordering and inter-frame gap.
        base = st_data.size();
        fb = fall_cyc.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_starts(base + 3, 200, "burst_timeout");
        settle();
        check("burst_count", 32'(st_data.size() - base), 32'd3);
        check("burst_b0", 32'(st_data[base]), 32'h11);
        check("burst_b1", 32'(st_data[base + 1]), 32'h22);
        check("burst_b2", 32'(st_data[base + 2]), 32'h33);
        check("burst_gap1", 32'(st_cyc[base + 1] - fall_cyc[fb]), 32'd2);
        check("burst_gap2", 32'(st_cyc[base + 2] - fall_cyc[fb + 1]), 32'd2);
        check("burst_spacing", 32'(st_cyc[base + 1] - st_cyc[base]), 32'd13);

        // Full and overflow while the transmitter is held busy.
        force_busy = 1'b1;
        step();
        base = st_data.size();
        for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i));
        check("full_flag", 32'(full), 32'd1);
        check("full_level", 32'(level), 32'd16);
        check("full_no_ovf", 32'(overflow), 32'd0);
        push(8'hEE);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd16);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        force_busy = 1'b0;
        wait_starts(base + 16, 400, "full_timeout");
        settle();
        check("full_drain_count", 32'(st_data.size() - base), 32'd16);
        for (int i = 0; i < DEPTH; i++) check("full_drain_order", 32'(st_data[base + i]), 32'(8'h40 + 8'(i)));

        // Full FIFO accepts a push in the same cycle as a pop.
        force_busy = 1'b1;
        step();
        base = st_data.size();
        for (int i = 0; i < DEPTH; i++) push(8'h60 + 8'(i));
        check("fp_full", 32'(full), 32'd1);
        force_busy = 1'b0;
        push(8'h5A);
        check("fp_no_ovf", 32'(overflow), 32'd0);
        check("fp_level", 32'(level), 32'd16);
        wait_starts(base + 17, 500, "fp_timeout");
        settle();
        check("fp_count", 32'(st_data.size() - base), 32'd17);
        check("fp_first", 32'(st_data[base]), 32'h60);
        check("fp_last", 32'(st_data[base + 16]), 32'h5A);

        // Flush with one byte in flight and three queued.
        base = st_data.size();
        fb = fall_cyc.size();
        push(8'h81);
        push(8'h82);
        push(8'h83);
        push(8'h84);
        check("flush_pre_level", 32'(level), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_level", 32'(level), 32'd0);
        settle();
        check("flush_starts", 32'(st_data.size() - base), 32'd1);
        check("flush_inflight", 32'(st_data[base]), 32'h81);
        check("flush_busy_fell", 32'(fall_cyc.size() - fb), 32'd1);

        // Asynchronous reset in the middle of a transfer.
        push(8'hC3);
        push(8'hC4);
        push(8'hC5);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_start", 32'(tx_start), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'h00);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_level", 32'(level), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = st_data.size();
        settle();
        check("arst_no_start", 32'(st_data.size() - base), 32'd0);
        push(8'h7E);
        step();
        check("arst_next_start", 32'(tx_start), 32'd1);
        check("arst_next_data", 32'(tx_data), 32'h7E);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer placed directly upstream of the UART transmitter. It accepts bytes from a producer at up to one per clock and stores them in a circular FIFO. It hands bytes to the transmitter one at a time through the transmitter's `start`/`data`/`busy` handshake, so producers never poll `busy` themselves. It adds level, full/empty and sticky-overflow status.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, minimum 2.
- `AW`, default $clog2(DEPTH): pointer width; derived, do not override.

- `clk`: input, 1 bit. System clock.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `wr_en`: input, 1 bit. Push `wr_data` this cycle.
- `wr_data`: input, 8 bits. Byte to push.
- `flush`: input, 1 bit. Synchronous FIFO clear.
- `clr_ovf`: input, 1 bit. Clears `overflow`.
- `full`: output, 1 bit. Level equals DEPTH.
- `empty`: output, 1 bit. Level equals 0.
- `level`: output, AW+1 bits. Stored byte count.
- `overflow`: output, 1 bit. Sticky flag: a push was dropped.
- `tx_start`: output, 1 bit. One-cycle start pulse to the transmitter `start`.
- `tx_data`: output, 8 bits. Byte to the transmitter `data`; valid while `tx_start` is high.
- `tx_busy`: input, 1 bit. From the transmitter `busy`.

## Operation
- Storage: `mem[DEPTH]` of 8-bit entries, plus `wr_ptr`/`rd_ptr` (AW bits, natural wrap) and `count` (AW+1 bits).
- `full` = (count==DEPTH); `empty` = (count==0); `level` = count. All three are combinational from registered state.
- Push is accepted when `wr_en` && (!full || pop). The write goes to `mem[wr_ptr]` and `wr_ptr` increments.
- Pop happens only on the IDLE->ISSUE transition. It loads `tx_data`<=mem[rd_ptr] and increments `rd_ptr`.
- Count update: push only +1; pop only -1; both at once, unchanged.
- Overflow: `wr_en` && full && !pop drops the byte and sets `overflow`. The flag stays set until `clr_ovf`. If set and clear arrive in the same cycle, set wins.
- Flush: zeroes `wr_ptr`, `rd_ptr` and `count`. It overrides a push in the same cycle. It does not abort a byte already issued; the FSM finishes its handshake normally. A flush in the same cycle as IDLE->ISSUE suppresses that transition, and the FSM stays IDLE.
- Handshake FSM, 2-bit state, one-hot decoding optional:
  - IDLE: if !empty && !tx_busy && !flush, go to ISSUE (this is the pop).
  - ISSUE: `tx_start`=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_busy`=1, then go to WAIT_DONE. The transmitter raises busy the cycle after start.
  - WAIT_DONE: stay until `tx_busy`=0, then go to IDLE.
- `tx_start` is registered, so there are no combinational paths from inputs to `tx_start`/`tx_data`.
- `tx_data` holds its value until the next pop.
- The transmitter latches `data` in the cycle `start` is high, so `tx_data` must be stable in ISSUE.
- Reset (async, any state): pointers, count, state=IDLE, `tx_start`=0, `tx_data`=0x00, `overflow`=0. Therefore `empty`=1, `full`=0, `level`=0. Memory contents are not reset. A byte in flight at reset is abandoned.

## Timing
- Push at edge N with FIFO empty and transmitter idle:
  - `empty` falls after edge N.
  - FSM enters ISSUE at edge N+1, so `tx_start`=1 and `tx_data` valid in cycle N+1.
  - Latency is 1 cycle from push to start.
- A push cannot bypass to `tx_data` in the same cycle.
- Between back-to-back frames, the FSM adds 2 clk cycles of gap after `tx_busy` falls: WAIT_DONE->IDLE, then IDLE->ISSUE.
- `tx_start` is never asserted while `tx_busy`=1, and never twice without an intervening busy 1->0.
- A full FIFO popping in cycle N still accepts a push in cycle N.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encodings: FS_IDLE, FS_ISSUE, FS_WAIT_BUSY, FS_WAIT_DONE.
  - The UART byte-width constant (8).
- Natural sub-module: `sync_fifo_mem`, the dual-pointer RAM with count and flags. The handshake FSM and overflow logic stay in `uart_tx_fifo`.

## Test plan
- Reset: assert `rst_n`=0 mid-transfer, asynchronously between edges. Required: `tx_start`=0, `tx_data`=0x00, `empty`=1, `level`=0 and `overflow`=0 immediately. After release, no start until the next push.
- Single byte: push 0xA5 at edge N, with a transmitter model that raises busy 1 cycle after start and holds it 10 cycles. Required: one `tx_start` pulse in cycle N+1 with `tx_data`=0xA5, and `level` back to 0 after N+1.
- Burst order: push 0x11, 0x22, 0x33 on consecutive cycles. Required:
  - Three start pulses, in the order 0x11, 0x22, 0x33.
  - Each pulse comes 2 cycles after the previous busy falls.
  - No pulse while busy=1.
- Full/overflow: hold busy=1, then push 17 bytes into DEPTH=16. Required:
  - `full`=1 after the 16th push.
  - 17th byte dropped and `overflow`=1.
  - `clr_ovf` clears the flag.
  - Release busy: the 16 original bytes come out in order.
- Full with simultaneous pop: with the FIFO full, push 0x5A in the same cycle IDLE->ISSUE occurs. Required: push accepted, `overflow` stays 0, and 0x5A emerges last.
- Flush: with 4 bytes queued and byte 1 in flight, assert `flush`. Required: byte 1's handshake completes, no further start pulses, `empty`=1 and `level`=0.
